// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: sequencer state encoding and the
// ADD/SUB opcode values.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_core.sv
// Single-bit full adder; the only arithmetic element of the serial ALU.
module full_adder_core (
    input  logic in_a,
    input  logic in_b,
    input  logic in_c,
    output logic s_out,
    output logic c_out
);

    assign s_out = in_a ^ in_b ^ in_c;
    assign c_out = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial add/subtract sequencer. One full adder is reused for every
// bit position, LSB first, one bit per clock. Subtraction is a + ~b + 1,
// so carry_out reads as "no borrow" for SUB.
module serial_alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    // Bit counter width, derived from WIDTH.
    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_r_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;

    logic             w_s_out;
    logic             w_c_out;
    logic             w_last;
    logic             w_c_msb_in;
    logic [WIDTH-1:0] w_r_sh_next;

    // The shared 1-bit adder sees the current LSBs and the running carry.
    full_adder_core u_fa (
        .in_a  (r_a_sh[0]),
        .in_b  (r_b_sh[0]),
        .in_c  (r_carry),
        .s_out (w_s_out),
        .c_out (w_c_out)
    );

    // Final bit is being processed when the counter reaches WIDTH-1.
    assign w_last      = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    // On the last bit the running carry is exactly the carry into the MSB.
    assign w_c_msb_in  = r_carry;
    assign w_r_sh_next = {w_s_out, r_r_sh[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept start only in IDLE, DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, serial shifting and carry chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_r_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= (op == OP_ADD) ? b_in : ~b_in;
                        r_carry <= (op == OP_ADD) ? 1'b0 : 1'b1;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_r_sh  <= w_r_sh_next;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c_out;
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result and flags load on the final bit so they are valid during DONE
    // and then hold through idle time and the whole next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_last) begin
            r_result    <= w_r_sh_next;
            r_carry_out <= w_c_out;
            r_overflow  <= w_c_msb_in ^ w_c_out;
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Testbench for serial_alu_sequencer (WIDTH=3): directed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written sequences for busy-start, mid-run reset and held start.
module tb_serial_alu_sequencer;
    import alu_pkg::*;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input logic o, input int x, input int y,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int sx, sy, full, sres;
        sx = (x >= 4) ? x - 8 : x;
        sy = (y >= 4) ? y - 8 : y;
        if (o == OP_ADD) begin
            full = x + y;
            c    = (full >= 8);
            sres = sx + sy;
        end else begin
            full = x - y;
            c    = (x >= y);
            sres = sx - sy;
        end
        r = full[W-1:0];
        v = (sres > 3) || (sres < -4);
    endfunction

    // Launch one operation, scramble inputs after capture, wait for done.
    // lat counts falling edges after the accepting edge until done is seen.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic c, output logic v,
                          output int lat);
        @(negedge clk);
        op = o; a_in = x; b_in = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = result; c = carry_out; v = overflow;
    endtask

    initial begin
        logic [W-1:0] r, er;
        logic         c, v, ec, ev;
        int           lat, nb, nd, prev_k;
        logic [W-1:0] rs;

        vecs[0] = '{op: OP_ADD, a: 3'b011, b: 3'b010, res: 3'b101, c: 1'b0, v: 1'b1};
        vecs[1] = '{op: OP_ADD, a: 3'b111, b: 3'b001, res: 3'b000, c: 1'b1, v: 1'b0};
        vecs[2] = '{op: OP_SUB, a: 3'b010, b: 3'b011, res: 3'b111, c: 1'b0, v: 1'b0};
        vecs[3] = '{op: OP_SUB, a: 3'b100, b: 3'b001, res: 3'b011, c: 1'b1, v: 1'b1};

        rst = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_result", 32'(result), 0);
        check("reset_carry", 32'(carry_out), 0);
        check("reset_ovf", 32'(overflow), 0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, c, v, lat);
            $display("vec %0d op=%0d a=%0d b=%0d -> res=%0d c=%0d v=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, r, c, v, lat);
            check("vec_latency", 32'(lat), W);
            check("vec_result", 32'(r), 32'(vecs[i].res));
            check("vec_carry", 32'(c), 32'(vecs[i].c));
            check("vec_ovf", 32'(v), 32'(vecs[i].v));
            @(negedge clk);
            check("vec_done_drop", 32'(done), 0);
            check("vec_busy_drop", 32'(busy), 0);
            @(negedge clk);
            check("vec_result_held", 32'(result), 32'(vecs[i].res));
        end

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            logic         ro;
            logic [W-1:0] ra, rb;
            ro = 1'($urandom);
            ra = W'($urandom_range(0, 7));
            rb = W'($urandom_range(0, 7));
            model(ro, int'(ra), int'(rb), er, ec, ev);
            run_op(ro, ra, rb, r, c, v, lat);
            $display("rand %0d op=%0d a=%0d b=%0d -> res=%0d c=%0d v=%0d (exp %0d %0d %0d)",
                     i, ro, ra, rb, r, c, v, er, ec, ev);
            check("rand_latency", 32'(lat), W);
            check("rand_result", 32'(r), 32'(er));
            check("rand_carry", 32'(c), 32'(ec));
            check("rand_ovf", 32'(v), 32'(ev));
        end

        // start pulsed while RUN must be ignored
        @(negedge clk);
        op = OP_ADD; a_in = 3'd3; b_in = 3'd2; start = 1'b1;
        nb = 0; nd = 0; rs = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin nd++; rs = result; end
            if (k == 1) begin start = 1'b1; a_in = 3'd1; b_in = 3'd1; end
            else start = 1'b0;
        end
        $display("busy-start: busy_cycles=%0d dones=%0d res=%0d", nb, nd, rs);
        check("busystart_busy_cycles", 32'(nb), 4);
        check("busystart_done_count", 32'(nd), 1);
        check("busystart_result", 32'(rs), 3'b101);

        // Reset in the second RUN cycle of ADD 7+1
        @(negedge clk);
        op = OP_ADD; a_in = 3'd7; b_in = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("midrun reset: busy=%0d done=%0d res=%0d c=%0d v=%0d",
                 busy, done, result, carry_out, overflow);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_result", 32'(result), 0);
        check("midrst_carry", 32'(carry_out), 0);
        check("midrst_ovf", 32'(overflow), 0);
        run_op(OP_ADD, 3'd1, 3'd1, r, c, v, lat);
        $display("post-reset ADD 1+1 -> res=%0d c=%0d v=%0d lat=%0d", r, c, v, lat);
        check("postrst_latency", 32'(lat), W);
        check("postrst_result", 32'(r), 3'b010);
        check("postrst_carry", 32'(c), 0);
        check("postrst_ovf", 32'(v), 0);

        // start held high: a result every WIDTH+2 cycles, busy low in between
        @(negedge clk);
        op = OP_ADD; a_in = 3'd3; b_in = 3'd2; start = 1'b1;
        nd = 0; prev_k = -1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (prev_k >= 0 && k == prev_k + 1)
                check("held_busy_gap", 32'(busy), 0);
            if (done) begin
                nd++;
                $display("held start: done at cycle %0d res=%0d", k, result);
                check("held_result", 32'(result), 3'b101);
                if (prev_k >= 0)
                    check("held_period", 32'(k - prev_k), W + 2);
                prev_k = k;
            end
        end
        start = 1'b0;
        check("held_done_count", 32'(nd), 3);
        repeat (6) @(negedge clk);
        check("final_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
